// File: rtl/buf_pipe_elastic.sv
// Elastic valid/ready buffer of DEPTH words with occupancy count and synchronous flush.
// Data words live in plain registers; only the pointers and LEVEL are reset.
module buf_pipe_elastic #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned LW = $clog2(DEPTH + 1)
) (
`ifdef USE_POWER_PINS
  inout  wire              VDD,
  inout  wire              VSS,
`endif
  input  logic             CLK,
  input  logic             RN,
  input  logic [WIDTH-1:0] I,
  input  logic             I_VALID,
  output logic             I_READY,
  output logic [WIDTH-1:0] Z,
  output logic             Z_VALID,
  input  logic             Z_READY,
  input  logic             FLUSH,
  output logic [LW-1:0]    LEVEL
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             push, pop;

  // Explicit compare-and-clear so non-power-of-2 depths wrap at DEPTH-1.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Ready depends only on RN and registered occupancy, never on Z_READY.
  assign I_READY = RN & (level_q != LW'(DEPTH));
  assign Z_VALID = (level_q != '0);
  assign Z       = Z_VALID ? mem_q[rd_ptr_q] : '0;
  assign LEVEL   = level_q;

  assign push = I_VALID & I_READY;
  assign pop  = Z_VALID & Z_READY;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (FLUSH) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      unique case ({push, pop})
        2'b10:   level_d = level_q + 1'b1;
        2'b01:   level_d = level_q - 1'b1;
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RN) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (push && !FLUSH) begin
      mem_q[wr_ptr_q] <= I;
    end
  end

`ifndef SYNTHESIS
  // A stalled producer must hold its word until it is accepted.
  producer_hold_a : assert property (@(posedge CLK) disable iff (!RN)
    (I_VALID && !I_READY && !FLUSH) |=> (I_VALID && $stable(I)));
`endif

endmodule
